uart_sfr_bridge: RTL and testbench
==================================

// Module: uart_sfr_bridge
// PURPOSE
//  8051 SFR front-end for the serial port, upstream of the Uart block. Decodes core SFR
//  accesses to SBUF/SCON, pushes TX bytes into the Uart FIFO write port (honouring is_full),
//  captures received bytes on rxd_int, keeps RI/TI/overrun flags and drives the serial IRQ.
//  Single clock domain (core clock); rxd_int is synchronised internally.
// PARAMETERS
//  SBUF_ADDR    8'h99  SFR address of SBUF (write = TX byte, read = last RX byte)
//  SCON_ADDR    8'h98  SFR address of SCON
//  DATA_WIDTH   8      byte width; must equal Uart FIFO_WIDTH
//  SYNC_STAGES  2      flops in the rxd_int synchroniser (>=2)
// PORTS
//  clk          in   1   core clock; also drives Uart fifo_w_clk
//  rst_n        in   1   asynchronous active-low reset
//  sfr_addr     in   8   SFR address
//  sfr_wr_en    in   1   SFR write strobe, one cycle
//  sfr_wr_data  in   8   SFR write data
//  sfr_rd_en    in   1   SFR read strobe, one cycle
//  sfr_rd_data  out  8   read data, valid the cycle after sfr_rd_en; 0 when not addressed
//  fifo_w_en    out  1   to Uart fifo_w_en, one-cycle pulse per byte
//  fifo_w_data  out  DW  to Uart fifo_w_data, stable while fifo_w_en high
//  fifo_full    in   1   from Uart is_full
//  rxd_int      in   1   from Uart rxd_int (foreign clock domain)
//  rx_data      in   DW  from Uart r_data; stable while rxd_int high
//  rx_ack       out  1   to Uart rxd_int_in; one-cycle pulse after each RX capture
//  uart_irq     out  1   serial interrupt request = RI | TI
// BEHAVIOUR
//  Reset: all outputs 0; SCON=8'h00; rx_buf=0; TX FSM in IDLE; sync chain cleared.
//  SCON map: [0]RI [1]TI [2]RXOV [3]TXOV [4]REN; [7:5] plain R/W storage.
//  SCON write: software may clear any flag or set REN/[7:5]; writing 1 to RI/TI/RXOV/TXOV is
//   ignored (hardware-set only). Same-cycle hardware set and software clear: set wins.
//  TX FSM IDLE: SBUF write with fifo_full=0 -> fifo_w_data<=byte, fifo_w_en=1 next cycle,
//   TI set in that same cycle. SBUF write with fifo_full=1 -> see TX_QUEUE below.
//  TX FSM PEND (macro only): held byte retried each cycle; first cycle with fifo_full=0 ->
//   fifo_w_en pulse, TI set, back to IDLE. SBUF write while PEND: dropped, TXOV set.
//  fifo_full is sampled the same cycle as the push decision; no push ever issued while full.
//  RX: rxd_int -> SYNC_STAGES flops -> rising-edge detect. On edge with REN=1: rx_buf<=rx_data,
//   RI set, rx_ack pulses next cycle; if RI already 1, RXOV set and rx_buf still overwritten.
//   Edge with REN=0: discarded, no flag, rx_ack still pulsed (Uart always released).
//  Latency rxd_int rise -> RI = SYNC_STAGES+1 cycles.
//  SBUF read returns rx_buf; does not clear RI. Reads of unmapped addresses return 8'h00.
//  uart_irq is OR of flag flops (no added latency, glitch-free).
//  Reset mid-operation: pending TX byte lost, no fifo_w_en after rst_n deasserts until a new write.
// CONFIGURATION
//  UART_SFR_TX_QUEUE_EN defined: one-entry hold register + PEND state as above.
//  Not defined: SBUF write while fifo_full=1 is dropped, TXOV set, TI unchanged; FSM never PEND.
// TESTING
//  1 Reset then SBUF write 8'h5A, full=0 -> fifo_w_en 1 cycle with data 8'h5A; TI=1; uart_irq=1.
//  2 full=1, SBUF write 8'hA5, full drops after 5 cycles -> with macro: one push of 8'hA5 the
//    cycle after full=0; without macro: no push, SCON[3]=1.
//  3 REN=1, rx_data=8'h3C, rxd_int pulse -> RI=1 after SYNC_STAGES+1 cycles, rx_ack 1 pulse,
//    SBUF read returns 8'h3C next cycle.
//  4 Second RX 8'hC3 before RI cleared -> RXOV=1, SBUF reads 8'hC3.
//  5 SCON write 8'h10 in same cycle as RI hardware set -> RI stays 1; next SCON write 8'h10 clears RI,TI,
//    uart_irq=0.
//  6 Assert rst_n=0 in PEND -> all outputs 0, no push after release.

Source files
------------

// File: rtl/uart_sfr_bridge.sv
// 8051 SBUF/SCON front-end for the Uart block: TX push, RX capture, flags and serial IRQ.
// Define UART_SFR_TX_QUEUE_EN to hold one TX byte while the FIFO is full.
module uart_sfr_bridge #(
  parameter logic [7:0]  SBUF_ADDR   = 8'h99,
  parameter logic [7:0]  SCON_ADDR   = 8'h98,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            sfr_addr_i,
  input  logic                  sfr_wr_en_i,
  input  logic [7:0]            sfr_wr_data_i,
  input  logic                  sfr_rd_en_i,
  output logic [7:0]            sfr_rd_data_o,
  output logic                  fifo_w_en_o,
  output logic [DATA_WIDTH-1:0] fifo_w_data_o,
  input  logic                  fifo_full_i,
  input  logic                  rxd_int_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  output logic                  rx_ack_o,
  output logic                  uart_irq_o
);

  typedef enum logic [0:0] {StIdle, StPend} tx_state_e;

  tx_state_e             state_q, state_d;
  logic                  w_en_q, w_en_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [7:0]            scon_q, scon_d;
  logic [DATA_WIDTH-1:0] rx_buf_q, rx_buf_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  rx_prev_q;
  logic                  rx_ack_q;
  logic [7:0]            rd_data_q, rd_data_d;
`ifdef UART_SFR_TX_QUEUE_EN
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
`endif

  logic wr_sbuf, wr_scon, rx_edge;
  logic ti_set, txov_set, ri_set, rxov_set;
  logic [3:0] flag_clr;

  assign wr_sbuf = sfr_wr_en_i && (sfr_addr_i == SBUF_ADDR);
  assign wr_scon = sfr_wr_en_i && (sfr_addr_i == SCON_ADDR);
  assign rx_edge = sync_q[SYNC_STAGES-1] & ~rx_prev_q;

  // TX push decision uses fifo_full_i from the same cycle; the pulse is registered.
  always_comb begin
    state_d  = state_q;
    w_en_d   = 1'b0;
    w_data_d = w_data_q;
    ti_set   = 1'b0;
    txov_set = 1'b0;
`ifdef UART_SFR_TX_QUEUE_EN
    hold_d   = hold_q;
`endif
    case (state_q)
      StIdle: begin
        if (wr_sbuf) begin
          if (!fifo_full_i) begin
            w_en_d   = 1'b1;
            w_data_d = DATA_WIDTH'(sfr_wr_data_i);
            ti_set   = 1'b1;
          end else begin
`ifdef UART_SFR_TX_QUEUE_EN
            hold_d  = DATA_WIDTH'(sfr_wr_data_i);
            state_d = StPend;
`else
            txov_set = 1'b1;
`endif
          end
        end
      end
      StPend: begin
`ifdef UART_SFR_TX_QUEUE_EN
        if (!fifo_full_i) begin
          w_en_d   = 1'b1;
          w_data_d = hold_q;
          ti_set   = 1'b1;
          state_d  = StIdle;
        end
        if (wr_sbuf) txov_set = 1'b1;
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Flags are hardware-set only; software writes of 0 clear them, and a set wins a clear.
  always_comb begin
    ri_set   = rx_edge & scon_q[4];
    rxov_set = ri_set & scon_q[0];
    flag_clr = {4{wr_scon}} & ~sfr_wr_data_i[3:0];
    scon_d[0]   = ri_set   | (scon_q[0] & ~flag_clr[0]);
    scon_d[1]   = ti_set   | (scon_q[1] & ~flag_clr[1]);
    scon_d[2]   = rxov_set | (scon_q[2] & ~flag_clr[2]);
    scon_d[3]   = txov_set | (scon_q[3] & ~flag_clr[3]);
    scon_d[7:4] = wr_scon ? sfr_wr_data_i[7:4] : scon_q[7:4];
    rx_buf_d    = ri_set ? rx_data_i : rx_buf_q;
  end

  always_comb begin
    rd_data_d = 8'h00;
    if (sfr_rd_en_i) begin
      if (sfr_addr_i == SBUF_ADDR)      rd_data_d = 8'(rx_buf_q);
      else if (sfr_addr_i == SCON_ADDR) rd_data_d = scon_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      w_en_q    <= 1'b0;
      w_data_q  <= '0;
      scon_q    <= 8'h00;
      rx_buf_q  <= '0;
      sync_q    <= '0;
      rx_prev_q <= 1'b0;
      rx_ack_q  <= 1'b0;
      rd_data_q <= 8'h00;
`ifdef UART_SFR_TX_QUEUE_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      w_en_q    <= w_en_d;
      w_data_q  <= w_data_d;
      scon_q    <= scon_d;
      rx_buf_q  <= rx_buf_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rxd_int_i};
      rx_prev_q <= sync_q[SYNC_STAGES-1];
      // Ack every edge, even with REN=0, so the Uart is always released.
      rx_ack_q  <= rx_edge;
      rd_data_q <= rd_data_d;
`ifdef UART_SFR_TX_QUEUE_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign sfr_rd_data_o = rd_data_q;
  assign fifo_w_en_o   = w_en_q;
  assign fifo_w_data_o = w_data_q;
  assign rx_ack_o      = rx_ack_q;
  assign uart_irq_o    = scon_q[0] | scon_q[1];

endmodule

// File: tb/tb_uart_sfr_bridge.sv
// Self-checking bench for uart_sfr_bridge: SFR vector table, TX scoreboard, RX/TX corner cases.
module tb_uart_sfr_bridge;
  localparam int unsigned DW = 8;
  localparam int unsigned SS = 2;
`ifdef UART_SFR_TX_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    sfr_addr = 8'h00;
  logic          sfr_wr_en = 1'b0;
  logic [7:0]    sfr_wr_data = 8'h00;
  logic          sfr_rd_en = 1'b0;
  logic [7:0]    sfr_rd_data;
  logic          fifo_w_en;
  logic [DW-1:0] fifo_w_data;
  logic          fifo_full = 1'b0;
  logic          rxd_int = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_ack;
  logic          uart_irq;

  always #5 clk = ~clk;

  uart_sfr_bridge #(
    .SBUF_ADDR  (8'h99),
    .SCON_ADDR  (8'h98),
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sfr_addr_i   (sfr_addr),
    .sfr_wr_en_i  (sfr_wr_en),
    .sfr_wr_data_i(sfr_wr_data),
    .sfr_rd_en_i  (sfr_rd_en),
    .sfr_rd_data_o(sfr_rd_data),
    .fifo_w_en_o  (fifo_w_en),
    .fifo_w_data_o(fifo_w_data),
    .fifo_full_i  (fifo_full),
    .rxd_int_i    (rxd_int),
    .rx_data_i    (rx_data),
    .rx_ack_o     (rx_ack),
    .uart_irq_o   (uart_irq)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] tx_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every FIFO push must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && fifo_w_en) begin
      if (tx_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_unexpected: got push %0h expected none", fifo_w_data);
      end else begin
        chk("tx_data", fifo_w_data, tx_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic sfr_op(input logic wr, input logic rd, input logic [7:0] addr,
                        input logic [7:0] data);
    sfr_wr_en   = wr;
    sfr_rd_en   = rd;
    sfr_addr    = addr;
    sfr_wr_data = data;
    @(negedge clk);
    sfr_wr_en = 1'b0;
    sfr_rd_en = 1'b0;
  endtask

  task automatic sfr_read(input logic [7:0] addr, input logic [7:0] exp, input string name);
    sfr_op(1'b0, 1'b1, addr, 8'h00);
    chk(name, sfr_rd_data, exp);
  endtask

  task automatic rx_wait_ack(input logic [7:0] data, input string name);
    bit got;
    got     = 1'b0;
    rx_data = data;
    rxd_int = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rx_ack) got = 1'b1;
    end
    chk(name, 8'(got), 8'd1);
    rxd_int = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic       exp_irq;
    logic       exp_push;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int   lat;
    logic ack_at;

    vecs[0]  = '{1'b0, 1'b1, 8'h98, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h99, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h55, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h99, 8'h5A, 8'h00, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 8'h98, 8'h00, 8'h02, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h98, 8'hFF, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h98, 8'h00, 8'hF2, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h98, 8'hE0, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h98, 8'h00, 8'hE0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h99, 8'hC3, 8'h00, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 8'h99, 8'h0F, 8'h00, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 8'h98, 8'h10, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h98, 8'h00, 8'h10, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 8'h97, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'h98, 8'h00, 8'h10, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_w_en", 8'(fifo_w_en), 8'd0);
    chk("rst_irq", 8'(uart_irq), 8'd0);
    chk("rst_ack", 8'(rx_ack), 8'd0);
    chk("rst_rd", sfr_rd_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].exp_push) tx_q.push_back(vecs[i].data);
      sfr_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data);
      chk($sformatf("vec%0d_rd", i), sfr_rd_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), 8'(uart_irq), 8'(vecs[i].exp_irq));
      chk($sformatf("vec%0d_wen", i), 8'(fifo_w_en), 8'(vecs[i].exp_push));
    end

    // RX capture latency and single-cycle ack (REN=1 here)
    lat     = 0;
    ack_at  = 1'b0;
    rx_data = 8'h3C;
    rxd_int = 1'b1;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (uart_irq) begin
        lat    = k;
        ack_at = rx_ack;
      end
    end
    chk("rx_latency", 8'(lat), 8'(SS + 1));
    chk("rx_ack_with_ri", 8'(ack_at), 8'd1);
    @(negedge clk);
    chk("rx_ack_one_cycle", 8'(rx_ack), 8'd0);
    rxd_int = 1'b0;
    repeat (3) @(negedge clk);
    sfr_read(8'h99, 8'h3C, "rx1_sbuf");
    sfr_read(8'h98, 8'h11, "rx1_scon");

    // Second byte before RI cleared -> overrun, buffer overwritten
    rx_wait_ack(8'hC3, "rx2_ack");
    sfr_read(8'h98, 8'h15, "rx2_scon_ov");
    sfr_read(8'h99, 8'hC3, "rx2_sbuf");

    // SCON clear in the same cycle as RI hardware set
    sfr_op(1'b1, 1'b0, 8'h98, 8'h10);
    chk("clr_irq", 8'(uart_irq), 8'd0);
    rx_data = 8'h77;
    rxd_int = 1'b1;
    repeat (2) @(negedge clk);
    sfr_op(1'b1, 1'b0, 8'h98, 8'h10);
    chk("ri_set_wins_irq", 8'(uart_irq), 8'd1);
    rxd_int = 1'b0;
    sfr_read(8'h98, 8'h11, "ri_set_wins_scon");
    sfr_op(1'b1, 1'b0, 8'h98, 8'h10);
    chk("ri_clr_irq", 8'(uart_irq), 8'd0);
    sfr_read(8'h98, 8'h10, "ri_clr_scon");
    repeat (3) @(negedge clk);

    // REN=0: byte discarded but Uart still acked
    sfr_op(1'b1, 1'b0, 8'h98, 8'h00);
    rx_wait_ack(8'h99, "ren0_ack");
    sfr_read(8'h98, 8'h00, "ren0_scon");
    sfr_read(8'h99, 8'h77, "ren0_sbuf");

    // SBUF writes while FIFO full
    fifo_full = 1'b1;
    sfr_op(1'b1, 1'b0, 8'h99, 8'hA5);
    chk("full_no_push", 8'(fifo_w_en), 8'd0);
    sfr_op(1'b1, 1'b0, 8'h99, 8'h11);
    repeat (3) @(negedge clk);
    chk("full_still_no_push", 8'(fifo_w_en), 8'd0);
    fifo_full = 1'b0;
    if (QEN) tx_q.push_back(8'hA5);
    @(negedge clk);
    chk("pend_push", 8'(fifo_w_en), 8'(QEN));
    @(negedge clk);
    chk("pend_push_once", 8'(fifo_w_en), 8'd0);
    sfr_read(8'h98, QEN ? 8'h0A : 8'h08, "full_scon");
    chk("full_irq", 8'(uart_irq), 8'(QEN));

    // Reset while a byte may be pending
    fifo_full = 1'b1;
    sfr_op(1'b1, 1'b0, 8'h99, 8'h22);
    rst_n = 1'b0;
    #1;
    chk("rst2_w_en", 8'(fifo_w_en), 8'd0);
    chk("rst2_irq", 8'(uart_irq), 8'd0);
    chk("rst2_ack", 8'(rx_ack), 8'd0);
    chk("rst2_rd", sfr_rd_data, 8'h00);
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst2_no_push", 8'(fifo_w_en), 8'd0);
    sfr_read(8'h98, 8'h00, "rst2_scon");

    chk("tx_queue_empty", 8'(tx_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
